// File: rtl/wb_if.sv
// Writeback-stage bus: port A/B result handshakes, regfile write port and,
// with WB_FWD_EN defined, the decode-side forwarding read ports.
interface wb_if;
    logic        a_valid;
    logic        a_ready;
    logic [4:0]  a_rd;
    logic [31:0] a_data;
    logic        b_valid;
    logic        b_ready;
    logic [4:0]  b_rd;
    logic [31:0] b_data;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
`ifdef WB_FWD_EN
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic [31:0] rf_rdata1;
    logic [31:0] rf_rdata2;
    logic [31:0] rdata1;
    logic [31:0] rdata2;

    modport slave (
        input  a_valid, a_rd, a_data, b_valid, b_rd, b_data,
        input  raddr1, raddr2, rf_rdata1, rf_rdata2,
        output a_ready, b_ready, wen, waddr, wdata, rdata1, rdata2
    );
    modport master (
        output a_valid, a_rd, a_data, b_valid, b_rd, b_data,
        output raddr1, raddr2, rf_rdata1, rf_rdata2,
        input  a_ready, b_ready, wen, waddr, wdata, rdata1, rdata2
    );
`else
    modport slave (
        input  a_valid, a_rd, a_data, b_valid, b_rd, b_data,
        output a_ready, b_ready, wen, waddr, wdata
    );
    modport master (
        output a_valid, a_rd, a_data, b_valid, b_rd, b_data,
        input  a_ready, b_ready, wen, waddr, wdata
    );
`endif
endinterface

// File: rtl/wb_stage.sv
// Writeback stage: merges ALU (port A) and buffered LSU/MDU (port B) results onto the
// regfile write port. Optional macro WB_FWD_EN adds same-cycle write-to-read forwarding.
// Handshake: a beat transfers on a cycle where valid && ready; ready never depends on valid.
module wb_stage #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 3
) (
    input logic clk,
    input logic rst,
    wb_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_entry_t;

    wb_entry_t       mem_q [DEPTH];
    wb_entry_t       mem_d [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [SW-1:0]   starve_cnt_q, starve_cnt_d;
    logic            wen_q, wen_d;
    logic [4:0]      waddr_q, waddr_d;
    logic [31:0]     wdata_q, wdata_d;

    logic            empty, full, starved, push, grant_a, grant_b;
    wb_entry_t       head;

    always_comb begin
        empty   = (count_q == '0);
        full    = (count_q == CW'(DEPTH));
        starved = (starve_cnt_q == SW'(STARVE_LIMIT)) && !empty;
        push    = bus.b_valid && !full;
        grant_a = !starved && bus.a_valid;
        grant_b = starved || (!bus.a_valid && !empty);
        head    = mem_q[rd_ptr_q];

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = '{rd: bus.b_rd, data: bus.b_data};
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (grant_b) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + CW'(push) - CW'(grant_b);

        // Count only cycles where a waiting head lost arbitration.
        starve_cnt_d = starve_cnt_q;
        if (empty || grant_b) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q != SW'(STARVE_LIMIT)) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end

        wen_d   = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (grant_a) begin
            wen_d   = (bus.a_rd != 5'd0);
            waddr_d = bus.a_rd;
            wdata_d = bus.a_data;
        end else if (grant_b) begin
            wen_d   = (head.rd != 5'd0);
            waddr_d = head.rd;
            wdata_d = head.data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            starve_cnt_q <= '0;
            wen_q        <= 1'b0;
            waddr_q      <= 5'd0;
            wdata_q      <= 32'd0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            starve_cnt_q <= starve_cnt_d;
            wen_q        <= wen_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
        end
        mem_q <= mem_d;
    end

    assign bus.a_ready = !starved;
    assign bus.b_ready = !full;
    assign bus.wen     = wen_q;
    assign bus.waddr   = waddr_q;
    assign bus.wdata   = wdata_q;

`ifdef WB_FWD_EN
    // Regfile writes land at the clock edge, so a same-cycle read must see wdata.
    assign bus.rdata1 = (wen_q && waddr_q == bus.raddr1 && bus.raddr1 != 5'd0) ?
                        wdata_q : bus.rf_rdata1;
    assign bus.rdata2 = (wen_q && waddr_q == bus.raddr2 && bus.raddr2 != 5'd0) ?
                        wdata_q : bus.rf_rdata2;
`endif
endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed vectors, per-port expected write queues
// checked by an independent monitor on the regfile write port.
module tb_wb_stage;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    logic [36:0] exp_a_q[$];
    logic [36:0] exp_b_q[$];

    wb_if bus_if ();

    wb_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    // clock/reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [36:0] act, input logic [36:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // driver tasks
    task automatic drive_a(input logic v, input logic [4:0] rd, input logic [31:0] d);
        bus_if.a_valid = v;
        bus_if.a_rd    = rd;
        bus_if.a_data  = d;
    endtask

    task automatic drive_b(input logic v, input logic [4:0] rd, input logic [31:0] d);
        bus_if.b_valid = v;
        bus_if.b_rd    = rd;
        bus_if.b_data  = d;
    endtask

    // monitor: every regfile write must be the next expected A or next expected B write
    always @(negedge clk) begin
        logic [36:0] got;
        logic [36:0] ha;
        logic [36:0] hb;
        if (bus_if.wen === 1'b1) begin
            got = {bus_if.waddr, bus_if.wdata};
            ha  = (exp_a_q.size() > 0) ? exp_a_q[0] : '1;
            hb  = (exp_b_q.size() > 0) ? exp_b_q[0] : '1;
            checks++;
            if (exp_a_q.size() > 0 && got == ha) begin
                void'(exp_a_q.pop_front());
            end else if (exp_b_q.size() > 0 && got == hb) begin
                void'(exp_b_q.pop_front());
            end else begin
                failures++;
                $display("FAIL wb_write actual=%h required_a_head=%h or_b_head=%h", got, ha, hb);
            end
        end
    end

    initial begin
        logic [31:0] bvec [4];
        checks   = 0;
        failures = 0;
        bvec[0] = 32'h8badf00d;
        bvec[1] = 32'hbaadcafe;
        bvec[2] = 32'h0ddba110;
        bvec[3] = 32'hfeedface;
        rst = 1'b1;
        drive_a(1'b0, 5'd0, 32'd0);
        drive_b(1'b0, 5'd0, 32'd0);
`ifdef WB_FWD_EN
        bus_if.raddr1    = 5'd0;
        bus_if.raddr2    = 5'd0;
        bus_if.rf_rdata1 = 32'd0;
        bus_if.rf_rdata2 = 32'd0;
`endif

        // reset
        step();
        step();
        rst = 1'b0;
        check("rst_wen", 37'(bus_if.wen), 37'd0);
        check("rst_waddr", 37'(bus_if.waddr), 37'd0);
        check("rst_wdata", 37'(bus_if.wdata), 37'd0);
        check("rst_a_ready", 37'(bus_if.a_ready), 37'd1);
        check("rst_b_ready", 37'(bus_if.b_ready), 37'd1);

        // single A write
        drive_a(1'b1, 5'd1, 32'hdeadbeef);
        check("a_ready_write", 37'(bus_if.a_ready), 37'd1);
        exp_a_q.push_back({5'd1, 32'hdeadbeef});
        step();
        drive_a(1'b0, 5'd0, 32'd0);
        check("a_write_wen", 37'(bus_if.wen), 37'd1);
        check("a_write_addr_data", {bus_if.waddr, bus_if.wdata}, {5'd1, 32'hdeadbeef});
        step();

        // x0 write via A: accepted, no wen
        drive_a(1'b1, 5'd0, 32'hb105f00d);
        check("x0_a_ready", 37'(bus_if.a_ready), 37'd1);
        step();
        drive_a(1'b0, 5'd0, 32'd0);
        check("x0_no_wen", 37'(bus_if.wen), 37'd0);
        step();

        // starvation: head forced through in the 4th cycle after its push
        for (int k = 0; k < 6; k++) begin
            drive_a(1'b1, 5'd2, 32'h10000000 + 32'(k));
            if (k == 0) begin
                drive_b(1'b1, 5'd3, 32'hcafed00d);
                check("starve_b_ready", 37'(bus_if.b_ready), 37'd1);
                exp_b_q.push_back({5'd3, 32'hcafed00d});
            end else begin
                drive_b(1'b0, 5'd0, 32'd0);
            end
            if (k == 4) begin
                check("starve_a_ready_low", 37'(bus_if.a_ready), 37'd0);
            end else begin
                check("starve_a_ready_high", 37'(bus_if.a_ready), 37'd1);
                exp_a_q.push_back({5'd2, 32'h10000000 + 32'(k)});
            end
            step();
            if (k == 4) begin
                check("starve_b_write", {31'(bus_if.wen), bus_if.waddr, bus_if.wdata} ,
                      {31'd1, 5'd3, 32'hcafed00d});
            end
        end
        drive_a(1'b0, 5'd0, 32'd0);
        step();
        step();

        // full FIFO: 4 pushes under A traffic, extra push refused while full
        for (int k = 0; k < 4; k++) begin
            drive_a(1'b1, 5'd2, 32'h20000000 + 32'(k));
            check("full_a_ready", 37'(bus_if.a_ready), 37'd1);
            exp_a_q.push_back({5'd2, 32'h20000000 + 32'(k)});
            drive_b(1'b1, 5'(4 + k), bvec[k]);
            check("fill_b_ready", 37'(bus_if.b_ready), 37'd1);
            exp_b_q.push_back({5'(4 + k), bvec[k]});
            step();
        end
        drive_a(1'b0, 5'd0, 32'd0);
        drive_b(1'b1, 5'd8, 32'h11111111);
        check("full_b_ready_low", 37'(bus_if.b_ready), 37'd0);
        step();
        drive_b(1'b0, 5'd0, 32'd0);
        check("b_ready_after_pop", 37'(bus_if.b_ready), 37'd1);
        for (int k = 0; k < 6; k++) step();

        // mid-operation reset with 3 entries queued
        for (int k = 0; k < 3; k++) begin
            drive_a(1'b1, 5'd9, 32'h30000000 + 32'(k));
            exp_a_q.push_back({5'd9, 32'h30000000 + 32'(k)});
            drive_b(1'b1, 5'(10 + k), 32'h44440001 + 32'(k));
            check("midrst_b_ready", 37'(bus_if.b_ready), 37'd1);
            step();
        end
        drive_a(1'b0, 5'd0, 32'd0);
        drive_b(1'b0, 5'd0, 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_wen", 37'(bus_if.wen), 37'd0);
        check("midrst_a_ready", 37'(bus_if.a_ready), 37'd1);
        check("midrst_b_ready_after", 37'(bus_if.b_ready), 37'd1);
        for (int k = 0; k < 4; k++) step();
        // x0 entry then a real one: first write after reset must be the new rd 13 entry
        drive_b(1'b1, 5'd0, 32'h66660000);
        step();
        drive_b(1'b1, 5'd13, 32'h55550001);
        exp_b_q.push_back({5'd13, 32'h55550001});
        step();
        drive_b(1'b0, 5'd0, 32'd0);
        check("x0_b_no_wen", 37'(bus_if.wen), 37'd0);
        step();
        step();

`ifdef WB_FWD_EN
        // forwarding
        drive_a(1'b1, 5'd1, 32'h8badf00d);
        exp_a_q.push_back({5'd1, 32'h8badf00d});
        step();
        drive_a(1'b0, 5'd0, 32'd0);
        bus_if.raddr1    = 5'd1;
        bus_if.rf_rdata1 = 32'hdeadbeef;
        bus_if.raddr2    = 5'd2;
        bus_if.rf_rdata2 = 32'h12345678;
        #1;
        check("fwd_rdata1_hit", 37'(bus_if.rdata1), 37'h8badf00d);
        check("fwd_rdata2_miss", 37'(bus_if.rdata2), 37'h12345678);
        bus_if.raddr1 = 5'd0;
        #1;
        check("fwd_rdata1_x0", 37'(bus_if.rdata1), 37'hdeadbeef);
        step();
`endif

        step();
        step();
        check("exp_a_drained", 37'(exp_a_q.size()), 37'd0);
        check("exp_b_drained", 37'(exp_b_q.size()), 37'd0);

        // final report
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
